// File: rtl/window_gen_l1_pkg.sv
// Shared constants and helpers for the layer-1 3x3 window generator.
// Counter widths come from cnt_w() so that every image dimension gets at least one bit.
package window_pkg;

    localparam int K          = 3;
    localparam int DEF_DATA_W = 16;
    localparam int DEF_IMG_W  = 28;
    localparam int DEF_IMG_H  = 28;
    localparam int DEF_COL_W  = $clog2(DEF_IMG_W);
    localparam int DEF_ROW_W  = $clog2(DEF_IMG_H);

    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Flat element index of window position (r,c); r0 is the oldest row, c0 the leftmost column.
    function automatic int win_idx(input int r, input int c);
        return r * K + c;
    endfunction

endpackage

// File: rtl/window_gen_l1_if.sv
// Pixel-in / window-out stream bundle for window_gen_l1.
// The master modport is the environment side, the slave modport is the generator.
interface window_gen_l1_if
    import window_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) ();

    logic                      in_valid;
    logic                      in_ready;
    logic [DATA_W-1:0]         in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [K*K*DATA_W-1:0]     out_win;
    logic                      out_last;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_win, out_last
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_win, out_last
    );

endinterface

// File: rtl/window_gen_l1_row_delay_en.sv
// DEPTH-stage, DATA_W-wide shift line advancing only when i_en is high.
// Output is the sample written DEPTH enabled cycles earlier.
module row_delay_en #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 28
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    logic [DATA_W-1:0] r_sr [DEPTH];

    // NOTE: storage arrays are deliberately left out of reset; a valid window only
    // forms after two full rows have been written, so stale contents never escape.
    always_ff @(posedge clk) begin
        if (i_en) begin
            r_sr[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_sr[i] <= r_sr[i-1];
            end
        end
    end

    assign o_data = r_sr[DEPTH-1];

endmodule

// File: rtl/window_gen_l1.sv
// Layer-1 3x3 sliding-window generator: two row delays align three raster rows and a
// single-entry output stage emits one window per fully-interior pixel position.
module window_gen_l1
    import window_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = DEF_IMG_W,
    parameter int IMG_H  = DEF_IMG_H
) (
    input  logic            clk,
    input  logic            rst,
    window_gen_l1_if.slave  bus
);

    localparam int COL_W = cnt_w(IMG_W);
    localparam int ROW_W = cnt_w(IMG_H);

    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_row;
    logic [DATA_W-1:0] r_win [K][K];
    logic              r_out_valid;
    logic              r_out_last;

    logic              w_accept;
    logic              w_col_end;
    logic              w_row_end;
    logic              w_emit;
    logic              w_last_px;
    logic [DATA_W-1:0] w_tap [K];

    // The output stage is a single register, so a new pixel is taken only if it is empty or draining.
    assign bus.in_ready = !rst && (!r_out_valid || bus.out_ready);
    assign w_accept     = bus.in_valid && bus.in_ready;

    assign w_col_end = (r_col == COL_W'(IMG_W - 1));
    assign w_row_end = (r_row == ROW_W'(IMG_H - 1));
    assign w_emit    = w_accept && (r_row >= ROW_W'(2)) && (r_col >= COL_W'(2));
    assign w_last_px = w_accept && w_row_end && w_col_end;

    assign w_tap[0] = bus.in_data;

    row_delay_en #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_dly0 (
        .clk    (clk),
        .i_en   (w_accept),
        .i_data (w_tap[0]),
        .o_data (w_tap[1])
    );

    row_delay_en #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_dly1 (
        .clk    (clk),
        .i_en   (w_accept),
        .i_data (w_tap[1]),
        .o_data (w_tap[2])
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + ROW_W'(1);
            end else begin
                r_col <= r_col + COL_W'(1);
            end
        end
    end

    // Window rows shift left on every accept, so row-edge pixels flush the previous row's columns.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < K; r++) begin
                for (int c = 0; c < K; c++) begin
                    r_win[r][c] <= '0;
                end
            end
        end else if (w_accept) begin
            for (int r = 0; r < K; r++) begin
                r_win[r][0] <= r_win[r][1];
                r_win[r][1] <= r_win[r][2];
                r_win[r][2] <= w_tap[K-1-r];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else if (w_accept) begin
            r_out_valid <= w_emit;
            r_out_last  <= w_last_px;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end
    end

    // NOTE: combinational blocks take a full default before the loop so no latch can form.
    always_comb begin
        bus.out_win = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                bus.out_win[win_idx(r, c)*DATA_W +: DATA_W] = r_win[r][c];
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_window_gen_l1.sv
// Self-checking bench for window_gen_l1 (4x4 image, 16-bit pixels) against a frame-array
// model: every emitted window is rebuilt from the stored image and checked on transfer.
module tb_window_gen_l1;

    localparam int DW = 16;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int WW = 9 * DW;

    typedef logic [WW-1:0] wide_t;

    typedef struct {
        wide_t win;
        logic  last;
    } exp_t;

    typedef struct {
        wide_t win;
        logic  last;
        int    cyc;
    } obs_t;

    logic clk;
    logic rst;

    window_gen_l1_if #(.DATA_W(DW)) bus ();

    window_gen_l1 #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state: the current frame as a 2D image plus the raster position of the next pixel.
    logic [DW-1:0] img [H][W];
    int            m_row = 0;
    int            m_col = 0;
    exp_t          exp_q[$];
    obs_t          obs_q[$];
    obs_t          ref_q[$];

    int    cyc            = 0;
    int    or_mode        = 0;
    int    held_cycles    = 0;
    bit    after_rst      = 0;
    bit    exp_valid_next = 0;
    bit    prev_stall     = 0;
    wide_t prev_win;
    logic  prev_last;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input wide_t act, input wide_t exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Consumer side: always ready, random, or held off until a window has waited five cycles.
    always begin
        @(posedge clk);
        #1;
        case (or_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 1) == 1);
            default: bus.out_ready = (held_cycles >= 5);
        endcase
    end

    // Compare process: inputs and outputs are stable at the falling edge, and the
    // handshakes seen here take effect at the following rising edge.
    always @(negedge clk) begin : monitor
        logic  acc;
        logic  xfer;
        exp_t  e;
        obs_t  o;
        wide_t w;
        cyc++;
        if (after_rst) begin
            check("reset_out_valid", wide_t'(bus.out_valid), wide_t'(0));
            check("reset_out_last", wide_t'(bus.out_last), wide_t'(0));
            check("reset_out_win", bus.out_win, wide_t'(0));
            after_rst = 0;
        end
        if (exp_valid_next) begin
            check("emit_latency", wide_t'(bus.out_valid), wide_t'(1));
            exp_valid_next = 0;
        end
        if (prev_stall) begin
            check("stall_valid", wide_t'(bus.out_valid), wide_t'(1));
            check("stall_win", bus.out_win, prev_win);
            check("stall_last", wide_t'(bus.out_last), wide_t'(prev_last));
        end
        check("in_ready", wide_t'(bus.in_ready),
              wide_t'(!rst && (!bus.out_valid || bus.out_ready)));
        acc  = bus.in_valid && bus.in_ready;
        xfer = bus.out_valid && bus.out_ready;
        if (bus.out_valid) begin
            check("window_expected", wide_t'(exp_q.size() > 0), wide_t'(1));
        end
        if (xfer && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("out_win", bus.out_win, e.win);
            check("out_last", wide_t'(bus.out_last), wide_t'(e.last));
            o.win  = bus.out_win;
            o.last = bus.out_last;
            o.cyc  = cyc;
            obs_q.push_back(o);
        end
        if (rst) begin
            exp_q.delete();
            m_row          = 0;
            m_col          = 0;
            after_rst      = 1;
            exp_valid_next = 0;
            prev_stall     = 0;
        end else begin
            if (acc) begin
                img[m_row][m_col] = bus.in_data;
                if (m_row >= 2 && m_col >= 2) begin
                    w = '0;
                    for (int i = 0; i < 3; i++) begin
                        for (int j = 0; j < 3; j++) begin
                            w[(i*3+j)*DW +: DW] = img[m_row-2+i][m_col-2+j];
                        end
                    end
                    e.win  = w;
                    e.last = (m_row == H - 1) && (m_col == W - 1);
                    exp_q.push_back(e);
                    exp_valid_next = 1;
                end
                m_col++;
                if (m_col == W) begin
                    m_col = 0;
                    m_row = (m_row + 1) % H;
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_win   = bus.out_win;
            prev_last  = bus.out_last;
            if (prev_stall) held_cycles++;
        end
    end

    // Send npix raster pixels; rnd selects random data instead of the 0x00RC pattern.
    task automatic send(input int npix, input bit rnd, input int gap_pct);
        int            r;
        int            c;
        int            tries;
        logic [DW-1:0] d;
        bit            acc;
        for (int k = 0; k < npix; k++) begin
            r     = (k / W) % H;
            c     = k % W;
            d     = rnd ? DW'($urandom) : DW'(r * 16 + c);
            acc   = 0;
            tries = 0;
            while (!acc && tries < 200) begin
                bus.in_valid = (int'($urandom_range(0, 99)) >= gap_pct);
                bus.in_data  = d;
                @(negedge clk);
                acc = bus.in_valid && bus.in_ready;
                @(posedge clk);
                #1;
                tries++;
            end
            check("accept_timeout", wide_t'(acc), wide_t'(1));
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() > 0 || bus.out_valid) && t < 200) begin
            @(posedge clk);
            #1;
            t++;
        end
        check("drain_timeout", wide_t'(t < 200), wide_t'(1));
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic cmp_ref(input string tag);
        int n;
        check({tag, "_count"}, wide_t'(obs_q.size()), wide_t'(ref_q.size()));
        n = (obs_q.size() < ref_q.size()) ? obs_q.size() : ref_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_win"}, obs_q[i].win, ref_q[i].win);
            check({tag, "_last"}, wide_t'(obs_q[i].last), wide_t'(ref_q[i].last));
        end
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        wide_t first_win;
        first_win = {16'h0022, 16'h0021, 16'h0020,
                     16'h0012, 16'h0011, 16'h0010,
                     16'h0002, 16'h0001, 16'h0000};
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Full frame, free-flowing.
        obs_q.delete();
        send(W * H, 0, 0);
        drain();
        check("t1_count", wide_t'(obs_q.size()), wide_t'(4));
        if (obs_q.size() == 4) begin
            check("t1_first_win", obs_q[0].win, first_win);
            check("t1_first_last", wide_t'(obs_q[0].last), wide_t'(0));
            check("t1_mid_last", wide_t'(obs_q[2].last), wide_t'(0));
            check("t1_final_last", wide_t'(obs_q[3].last), wide_t'(1));
            check("t1_final_topleft", wide_t'(obs_q[3].win[DW-1:0]), wide_t'(16'h0011));
            check("t1_final_botright", wide_t'(obs_q[3].win[8*DW +: DW]), wide_t'(16'h0033));
            check("t6_no_bubble", wide_t'(obs_q[1].cyc - obs_q[0].cyc), wide_t'(1));
        end
        ref_q = obs_q;

        // Back-pressure on the first window.
        held_cycles = 0;
        or_mode     = 2;
        obs_q.delete();
        send(W * H, 0, 0);
        drain();
        or_mode = 0;
        check("t2_stall_seen", wide_t'(held_cycles >= 5), wide_t'(1));
        cmp_ref("t2");

        // Random input gaps.
        obs_q.delete();
        send(W * H, 0, 50);
        drain();
        cmp_ref("t3");

        // Two back-to-back frames.
        obs_q.delete();
        send(2 * W * H, 0, 0);
        drain();
        check("t4_count", wide_t'(obs_q.size()), wide_t'(8));
        if (obs_q.size() == 8) begin
            check("t4_frame2_topleft", wide_t'(obs_q[4].win[DW-1:0]), wide_t'(16'h0000));
            check("t4_frame2_first", obs_q[4].win, first_win);
            check("t4_frame1_last", wide_t'(obs_q[3].last), wide_t'(1));
            check("t4_frame2_last", wide_t'(obs_q[7].last), wide_t'(1));
        end

        // Reset after pixel 0x0021, then a fresh frame.
        obs_q.delete();
        send(2 * W + 2, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("t5_no_window_before_rst", wide_t'(obs_q.size()), wide_t'(0));
        send(W * H, 0, 0);
        drain();
        cmp_ref("t5");

        // Random data, random gaps, random consumer.
        or_mode = 1;
        obs_q.delete();
        send(3 * W * H, 1, 30);
        drain();
        or_mode = 0;
        check("t7_count", wide_t'(obs_q.size()), wide_t'(3 * (H - 2) * (W - 2)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
